// File: rtl/tt_um_adder_tester.sv
// Exhaustive tester for an external 4-bit adder: drives every operand pair,
// checks the returned sums after LAT cycles and reports error count / first failure.
module tt_um_adder_tester #(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      r_state;
  logic        r_start_q;
  logic [7:0]  r_cnt;
  logic [7:0]  r_uo;
  logic [7:0]  r_err_cnt;
  logic [7:0]  r_first_fail;
  logic        r_fail;
  logic [1:0]  r_dcnt;
  logic        r_vld  [LAT];
  logic [4:0]  r_exp  [LAT];
  logic [7:0]  r_pair [LAT];

  logic        w_start_pulse;
  logic        w_active;
  logic        w_mismatch;
  logic [4:0]  w_exp;
  logic        w_unused;

  assign w_start_pulse = ui_in[0] & ~r_start_q;
  assign w_active      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_exp         = {1'b0, r_uo[7:4]} + {1'b0, r_uo[3:0]};
  assign w_mismatch    = w_active && r_vld[LAT-1] && (uio_in[4:0] != r_exp[LAT-1]);
  assign w_unused      = &{1'b0, ena, ui_in[7:3], uio_in[7:5]};

  // Stage 0 captures the pair driven during the cycle just ending; the last
  // stage lines up with the adder's returned sum LAT cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_start_q    <= 1'b1;
      r_cnt        <= 8'd0;
      r_uo         <= 8'd0;
      r_err_cnt    <= 8'd0;
      r_first_fail <= 8'd0;
      r_fail       <= 1'b0;
      r_dcnt       <= 2'd0;
      for (int i = 0; i < LAT; i++) begin
        r_vld[i]  <= 1'b0;
        r_exp[i]  <= 5'd0;
        r_pair[i] <= 8'd0;
      end
    end else begin
      r_start_q <= ui_in[0];

      r_vld[0]  <= (r_state == S_RUN);
      r_exp[0]  <= w_exp;
      r_pair[0] <= r_uo;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_exp[i]  <= r_exp[i-1];
        r_pair[i] <= r_pair[i-1];
      end

      if (w_mismatch) begin
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        r_fail <= 1'b1;
        if (!r_fail) r_first_fail <= r_pair[LAT-1];
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_pulse) begin
            r_state      <= S_RUN;
            r_uo         <= 8'd0;
            r_cnt        <= 8'd1;
            r_err_cnt    <= 8'd0;
            r_first_fail <= 8'd0;
            r_fail       <= 1'b0;
            for (int i = 0; i < LAT; i++) r_vld[i] <= 1'b0;
          end
        end
        S_RUN: begin
          if (r_uo == 8'hFF) begin
            r_state <= S_DRAIN;
            r_dcnt  <= 2'd0;
          end else begin
            r_uo  <= r_cnt;
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DRAIN: begin
          if (r_dcnt == 2'(LAT)) r_state <= S_DONE;
          else                   r_dcnt  <= r_dcnt + 2'd1;
        end
        default: r_state <= S_IDLE;
      endcase

      // Abort on error wins over normal sequencing; in-flight compares are dropped.
      if (w_mismatch && ui_in[1]) begin
        r_state <= S_DONE;
        for (int i = 0; i < LAT; i++) r_vld[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    uo_out = r_uo;
    case (r_state)
      S_IDLE:  uo_out = 8'd0;
      S_DONE:  uo_out = ui_in[2] ? r_first_fail : r_err_cnt;
      default: uo_out = r_uo;
    endcase
  end

  assign uio_out = {r_fail, (r_state == S_DONE), w_active, 5'b00000};
  assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_tt_um_adder_tester.sv
// Bench: two tester instances (LAT=1, LAT=3) each looped through a behavioural
// adder with injectable faults; expected run outcomes go through a scoreboard queue.
module tb_tt_um_adder_tester;

  localparam int LatA = 1;
  localparam int LatB = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uoOutA, uioInA, uioOutA, uioOeA;
  logic [7:0] uoOutB, uioInB, uioOutB, uioOeB;

  int         total = 0;
  int         bad = 0;
  int         faultMode = 0;
  logic [7:0] faultPair = 8'h00;
  logic [2:0] junk = 3'd0;
  logic [4:0] modelA;
  logic [4:0] modelB [3];

  typedef struct {
    string      tag;
    int         busyA;
    int         busyB;
    logic [7:0] errCnt;
    logic [7:0] firstFail;
    logic       fail;
  } exp_t;
  exp_t sbq[$];

  tt_um_adder_tester #(.LAT(LatA)) dutA (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui_in), .uo_out(uoOutA),
    .uio_in(uioInA), .uio_out(uioOutA), .uio_oe(uioOeA)
  );

  tt_um_adder_tester #(.LAT(LatB)) dutB (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui_in), .uo_out(uoOutB),
    .uio_in(uioInB), .uio_out(uioOutB), .uio_oe(uioOeB)
  );

  always #5 clk = ~clk;

  // Behavioural adder under test, with optional corruption.
  function automatic logic [4:0] modelAdd(input logic [7:0] p);
    logic [4:0] r;
    r = {1'b0, p[7:4]} + {1'b0, p[3:0]};
    if (faultMode == 1 && p == faultPair) r = r ^ 5'd1;
    if (faultMode == 2) r = 5'h1F;
    return r;
  endfunction

  always @(posedge clk) begin
    junk      <= 3'($urandom);
    modelA    <= modelAdd(uoOutA);
    modelB[0] <= modelAdd(uoOutB);
    modelB[1] <= modelB[0];
    modelB[2] <= modelB[1];
  end

  assign uioInA = {junk, modelA};
  assign uioInB = {junk, modelB[2]};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulse start (optionally a second time mid-run) and wait for both testers to finish.
  task automatic applyStimulus(input logic stopOnErr, input logic midStart, output int busyA, output int busyB);
    logic finished;
    busyA = 0;
    busyB = 0;
    finished = 1'b0;
    @(negedge clk);
    ui_in[1] = stopOnErr;
    ui_in[0] = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      ui_in[0] = (midStart && cyc == 50);
      if (uioOutA[5]) busyA++;
      if (uioOutB[5]) busyB++;
      if (uioOutA[6] && uioOutB[6]) begin
        finished = 1'b1;
        break;
      end
    end
    ui_in[1] = 1'b0;
    ui_in[0] = 1'b0;
    checkOutput("run_finished", {31'd0, finished}, 32'd1);
  endtask

  task automatic checkResult(input int busyA, input int busyB);
    exp_t e;
    e = sbq.pop_front();
    checkOutput({e.tag, "_busyA"}, busyA, e.busyA);
    checkOutput({e.tag, "_busyB"}, busyB, e.busyB);
    checkOutput({e.tag, "_uioA"}, uioOutA, {e.fail, 1'b1, 6'd0});
    checkOutput({e.tag, "_uioB"}, uioOutB, {e.fail, 1'b1, 6'd0});
    ui_in[2] = 1'b0;
    #1;
    checkOutput({e.tag, "_errA"}, uoOutA, e.errCnt);
    checkOutput({e.tag, "_errB"}, uoOutB, e.errCnt);
    ui_in[2] = 1'b1;
    #1;
    checkOutput({e.tag, "_firstA"}, uoOutA, e.firstFail);
    checkOutput({e.tag, "_firstB"}, uoOutB, e.firstFail);
    ui_in[2] = 1'b0;
  endtask

  initial begin
    int bA, bB;
    logic hit;
    rst_n = 1'b0;
    ui_in = 8'hF8;
    repeat (3) @(negedge clk);
    checkOutput("rst_uoA", uoOutA, 8'h00);
    checkOutput("rst_uioA", uioOutA, 8'h00);
    checkOutput("rst_oeA", uioOeA, 8'hE0);
    checkOutput("rst_oeB", uioOeB, 8'hE0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_uioB", uioOutB, 8'h00);
    checkOutput("idle_uoB", uoOutB, 8'h00);
    ui_in = 8'h00;

    $display("[TB] fault-free run with ignored second start");
    faultMode = 0;
    sbq.push_back('{"clean", 256 + LatA + 1, 256 + LatB + 1, 8'h00, 8'h00, 1'b0});
    applyStimulus(1'b0, 1'b1, bA, bB);
    checkResult(bA, bB);

    $display("[TB] single fault at pair 35");
    faultMode = 1;
    faultPair = 8'h35;
    sbq.push_back('{"fault35", 256 + LatA + 1, 256 + LatB + 1, 8'h01, 8'h35, 1'b1});
    applyStimulus(1'b0, 1'b0, bA, bB);
    checkResult(bA, bB);

    $display("[TB] stuck result, error count saturates");
    faultMode = 2;
    sbq.push_back('{"stuck", 256 + LatA + 1, 256 + LatB + 1, 8'hFF, 8'h00, 1'b1});
    applyStimulus(1'b0, 1'b0, bA, bB);
    checkResult(bA, bB);

    $display("[TB] stop on first error at pair 12");
    faultMode = 1;
    faultPair = 8'h12;
    sbq.push_back('{"stop12", 8'h12 + LatA + 1, 8'h12 + LatB + 1, 8'h01, 8'h12, 1'b1});
    applyStimulus(1'b1, 1'b0, bA, bB);
    checkResult(bA, bB);

    $display("[TB] reset mid-run with start held high");
    faultMode = 0;
    @(negedge clk);
    ui_in[0] = 1'b1;
    hit = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (uoOutA == 8'h80) begin
        hit = 1'b1;
        break;
      end
    end
    checkOutput("abort_reached80", {31'd0, hit}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_uoA", uoOutA, 8'h00);
    checkOutput("abort_uioA", uioOutA, 8'h00);
    checkOutput("abort_uoB", uoOutB, 8'h00);
    checkOutput("abort_uioB", uioOutB, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("held_uioA", uioOutA, 8'h00);
    checkOutput("held_uoB", uoOutB, 8'h00);
    ui_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("low_uioA", uioOutA, 8'h00);
    sbq.push_back('{"restart", 256 + LatA + 1, 256 + LatB + 1, 8'h00, 8'h00, 1'b0});
    applyStimulus(1'b0, 1'b0, bA, bB);
    checkResult(bA, bB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
